// File: rtl/logic_alu_pipe_if.sv
// Handshake bus for logic_alu_pipe: operand beat in, result beat with flags out.
// master drives operands and out_ready; slave is the pipeline itself.
interface logic_alu_pipe_if #(
  parameter int WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             cf;
  logic             sf;
  logic             zf;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, z, cf, sf, zf, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, z, cf, sf, zf, busy
  );
endinterface

// File: rtl/logic_alu_pipe.sv
// Two-stage valid/ready logic/shift unit: S1 captures operands, S2 registers
// the result and carry/sign/zero flags. Full backpressure, 2 beats in flight.
module logic_alu_pipe #(
  parameter int WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_alu_pipe_if.slave   bus
);

  logic             s1_valid_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] z_reg;
  logic             cf_reg;
  logic             sf_reg;
  logic             zf_reg;

  logic             s1_load;
  logic             s2_load;
  logic             in_ready_next;

  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] xor_v;
  logic [WIDTH-1:0] z_next;
  logic             cf_next;

  // S2 can take a new beat when it is empty or its beat leaves this cycle.
  assign s2_load       = s1_valid_reg & (~out_valid_reg | bus.out_ready);
  assign in_ready_next = ~s1_valid_reg | s2_load;
  assign s1_load       = bus.in_valid & in_ready_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign and_v[gi] = a_reg[gi] & b_reg[gi];
      assign or_v[gi]  = a_reg[gi] | b_reg[gi];
      assign xor_v[gi] = a_reg[gi] ^ b_reg[gi];
    end
  endgenerate

  always_comb begin
    z_next  = '0;
    cf_next = 1'b0;
    case (op_reg)
      3'b000: z_next = and_v;
      3'b001: z_next = or_v;
      3'b010: z_next = xor_v;
      3'b011: z_next = ~and_v;
      3'b100: z_next = ~or_v;
      3'b101: z_next = ~xor_v;
      3'b110: begin
        z_next  = {a_reg[WIDTH-2:0], 1'b0};
        cf_next = a_reg[WIDTH-1];
      end
      3'b111: begin
        z_next  = {1'b0, a_reg[WIDTH-1:1]};
        cf_next = a_reg[0];
      end
      default: begin
        z_next  = '0;
        cf_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= 1'b1;
        a_reg        <= bus.a;
        b_reg        <= bus.b;
        op_reg       <= bus.op;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  // Result registers only change on s2_load, so a stalled beat holds bit-for-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      z_reg         <= '0;
      cf_reg        <= 1'b0;
      sf_reg        <= 1'b0;
      zf_reg        <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid_reg <= 1'b1;
        z_reg         <= z_next;
        cf_reg        <= cf_next;
        sf_reg        <= z_next[WIDTH-1];
        zf_reg        <= (z_next == '0);
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_next;
  assign bus.out_valid = out_valid_reg;
  assign bus.z         = z_reg;
  assign bus.cf        = cf_reg;
  assign bus.sf        = sf_reg;
  assign bus.zf        = zf_reg;
  assign bus.busy      = s1_valid_reg | out_valid_reg;

endmodule

// File: tb/tb_logic_alu_pipe.sv
// Directed WIDTH=5 checks plus a randomized WIDTH=16 scoreboard run for
// logic_alu_pipe, compared against an arithmetic reference model.
module tb_logic_alu_pipe;

  logic clk;
  logic rst_n;

  logic_alu_pipe_if #(.WIDTH(5))  p5 ();
  logic_alu_pipe_if #(.WIDTH(16)) p16 ();

  logic_alu_pipe #(.WIDTH(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (p5)
  );

  logic_alu_pipe #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (p16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] z;
    logic        cf;
    logic        sf;
    logic        zf;
  } res_t;

  // Result as packed {z, cf, sf, zf} from the op table, using plain arithmetic.
  function automatic logic [34:0] ref_alu(input int w, input logic [31:0] ai,
                                          input logic [31:0] bi, input logic [2:0] opi);
    logic [31:0] mask;
    logic [31:0] av;
    logic [31:0] bv;
    res_t r;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    av   = ai & mask;
    bv   = bi & mask;
    r.cf = 1'b0;
    case (opi)
      3'd0: r.z = av & bv;
      3'd1: r.z = av | bv;
      3'd2: r.z = av ^ bv;
      3'd3: r.z = ~(av & bv);
      3'd4: r.z = ~(av | bv);
      3'd5: r.z = ~(av ^ bv);
      3'd6: begin r.z = av << 1; r.cf = ((av >> (w - 1)) & 32'h1) != 0; end
      default: begin r.z = av >> 1; r.cf = (av & 32'h1) != 0; end
    endcase
    r.z  = r.z & mask;
    r.sf = ((r.z >> (w - 1)) & 32'h1) != 0;
    r.zf = (r.z == 32'h0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] out5();
    res_t r;
    r.z  = {27'd0, p5.z};
    r.cf = p5.cf;
    r.sf = p5.sf;
    r.zf = p5.zf;
    return r;
  endfunction

  function automatic logic [34:0] out16();
    res_t r;
    r.z  = {16'd0, p16.z};
    r.cf = p16.cf;
    r.sf = p16.sf;
    r.zf = p16.zf;
    return r;
  endfunction

  function automatic logic [34:0] mk(input logic [31:0] zv, input logic c, input logic s, input logic zz);
    res_t r;
    r.z = zv; r.cf = c; r.sf = s; r.zf = zz;
    return r;
  endfunction

  // One isolated beat with out_ready=1: result must appear exactly two edges later.
  task automatic beat5(input string tag, input logic [4:0] ai, input logic [4:0] bi,
                       input logic [2:0] opi, input logic [34:0] exp);
    @(negedge clk);
    p5.in_valid = 1'b1; p5.a = ai; p5.b = bi; p5.op = opi; p5.out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, {34'd0, p5.in_ready}, 35'd1);
    @(posedge clk);
    @(negedge clk);
    p5.in_valid = 1'b0;
    #1 check({tag, "_early"}, {34'd0, p5.out_valid}, 35'd0);
    @(negedge clk);
    #1 check({tag, "_valid"}, {34'd0, p5.out_valid}, 35'd1);
    check({tag, "_result"}, out5(), exp);
  endtask

  logic [34:0] exp_q5[$];
  logic [34:0] exp_q16[$];
  logic [34:0] e0, e1, e2;
  logic [4:0]  ra, rb;
  int n_iss, n_rcv;

  initial begin
    rst_n = 1'b0;
    p5.in_valid = 1'b0;  p5.a = '0;  p5.b = '0;  p5.op = '0;  p5.out_ready = 1'b1;
    p16.in_valid = 1'b0; p16.a = '0; p16.b = '0; p16.op = '0; p16.out_ready = 1'b1;

    #1;
    check("rst_out_valid", {34'd0, p5.out_valid}, 35'd0);
    check("rst_busy",      {34'd0, p5.busy},      35'd0);
    check("rst_in_ready",  {34'd0, p5.in_ready},  35'd1);
    check("rst_result",    out5(), mk(32'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single beats
    beat5("and_a", 5'b10101, 5'b01100, 3'd0, mk(32'b00100, 1'b0, 1'b0, 1'b0));
    beat5("and_b", 5'b11100, 5'b00000, 3'd0, mk(32'b00000, 1'b0, 1'b0, 1'b1));
    beat5("shl1",  5'b10110, 5'b11111, 3'd6, mk(32'b01100, 1'b1, 1'b0, 1'b0));
    beat5("shr1",  5'b00001, 5'b10101, 3'd7, mk(32'b00000, 1'b1, 1'b0, 1'b1));
    beat5("nor",   5'b00000, 5'b00000, 3'd4, mk(32'b11111, 1'b0, 1'b1, 1'b0));

    // Back-to-back: all 8 ops, one per cycle
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        check("b2b_valid", {34'd0, p5.out_valid}, 35'd1);
        check("b2b_result", out5(), exp_q5.pop_front());
      end
      if (k < 8) begin
        ra = 5'($urandom); rb = 5'($urandom);
        p5.in_valid = 1'b1; p5.a = ra; p5.b = rb; p5.op = 3'(k);
        exp_q5.push_back(ref_alu(5, {27'd0, ra}, {27'd0, rb}, 3'(k)));
      end else begin
        p5.in_valid = 1'b0;
      end
      #1;
      if (k < 8) check("b2b_in_ready", {34'd0, p5.in_ready}, 35'd1);
      @(negedge clk);
    end

    // Backpressure: three beats offered while the consumer stalls
    e0 = ref_alu(5, 32'b11010, 32'b01111, 3'd2);
    e1 = ref_alu(5, 32'b10011, 32'b00110, 3'd1);
    e2 = ref_alu(5, 32'b01101, 32'b00000, 3'd5);
    p5.out_ready = 1'b0;
    p5.in_valid = 1'b1; p5.a = 5'b11010; p5.b = 5'b01111; p5.op = 3'd2;
    #1 check("bp_acc0", {34'd0, p5.in_ready}, 35'd1);
    @(negedge clk);
    p5.a = 5'b10011; p5.b = 5'b00110; p5.op = 3'd1;
    #1 check("bp_acc1", {34'd0, p5.in_ready}, 35'd1);
    @(negedge clk);
    p5.a = 5'b01101; p5.b = 5'b00000; p5.op = 3'd5;
    #1 check("bp_full", {34'd0, p5.in_ready}, 35'd0);
    check("bp_head", out5(), e0);
    @(negedge clk);
    #1 check("bp_still_full", {34'd0, p5.in_ready}, 35'd0);
    check("bp_hold", out5(), e0);
    check("bp_hold_valid", {34'd0, p5.out_valid}, 35'd1);
    p5.out_ready = 1'b1;
    #1 check("bp_ready_follow", {34'd0, p5.in_ready}, 35'd1);
    @(negedge clk);
    p5.in_valid = 1'b0; p5.out_ready = 1'b0;
    #1 check("bp_second", out5(), e1);
    check("bp_second_valid", {34'd0, p5.out_valid}, 35'd1);
    p5.out_ready = 1'b1;
    @(negedge clk);
    #1 check("bp_third", out5(), e2);
    check("bp_third_valid", {34'd0, p5.out_valid}, 35'd1);
    @(negedge clk);
    #1 check("bp_drained", {34'd0, p5.busy}, 35'd0);

    // Reset with both stages full
    p5.out_ready = 1'b0;
    p5.in_valid = 1'b1; p5.a = 5'b11111; p5.b = 5'b10000; p5.op = 3'd0;
    @(negedge clk);
    p5.a = 5'b00000; p5.b = 5'b00000; p5.op = 3'd4;
    @(negedge clk);
    p5.in_valid = 1'b0;
    #1 check("rmf_full_busy", {34'd0, p5.busy}, 35'd1);
    check("rmf_full_ready", {34'd0, p5.in_ready}, 35'd0);
    check("rmf_full_valid", {34'd0, p5.out_valid}, 35'd1);
    #1 rst_n = 1'b0;
    #1 check("rmf_valid", {34'd0, p5.out_valid}, 35'd0);
    check("rmf_busy",   {34'd0, p5.busy},      35'd0);
    check("rmf_result", out5(), mk(32'd0, 1'b0, 1'b0, 1'b0));
    check("rmf_ready",  {34'd0, p5.in_ready},  35'd1);
    @(negedge clk);
    rst_n = 1'b1;
    p5.out_ready = 1'b1;
    beat5("post_rst", 5'b11111, 5'b11111, 3'd0, mk(32'b11111, 1'b0, 1'b1, 1'b0));

    // WIDTH=16 random regression with random valid/ready toggling
    n_iss = 0; n_rcv = 0;
    for (int cyc = 0; cyc < 20000 && n_rcv < 1000; cyc++) begin
      @(negedge clk);
      p16.in_valid  = (n_iss < 1000) && ($urandom_range(0, 3) != 0);
      p16.a         = 16'($urandom);
      p16.b         = 16'($urandom);
      p16.op        = 3'($urandom);
      p16.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (p16.out_valid) begin
        check("rand_nonempty", {34'd0, exp_q16.size() > 0}, 35'd1);
        if (exp_q16.size() > 0) begin
          check("rand_beat", out16(), exp_q16[0]);
          if (p16.out_ready) begin
            void'(exp_q16.pop_front());
            n_rcv++;
          end
        end
      end
      if (p16.in_valid && p16.in_ready) begin
        exp_q16.push_back(ref_alu(16, {16'd0, p16.a}, {16'd0, p16.b}, p16.op));
        n_iss++;
      end
    end
    check("rand_count", 35'(n_rcv), 35'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
